// File: rtl/sdram_ctrl.sv
// Single-port SDR SDRAM command sequencer: power-up init, periodic auto-refresh and
// single-beat read/write with auto-precharge. All SDRAM pin outputs are registered.
module sdram_ctrl #(
  parameter int unsigned INIT_CYCLES      = 100,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RFC            = 7,
  parameter int unsigned T_MRD            = 2,
  parameter int unsigned T_WR             = 2,
  parameter int unsigned CAS_LAT          = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        ENABLE,
  input  logic        W_EN,
  input  logic        R_EN,
  input  logic [1:0]  MEM_BA,
  input  logic [11:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  output logic        BUSYn,
  output logic [31:0] HRDATA_R,
  output logic        INIT_DONE,
  output logic        SD_CKE,
  output logic        SD_CSn,
  output logic        SD_RASn,
  output logic        SD_CASn,
  output logic        SD_WEn,
  output logic [1:0]  SD_BA,
  output logic [11:0] SD_A,
  output logic [3:0]  SD_DQM,
  output logic [31:0] SD_DQ_OUT,
  output logic        SD_DQ_OE,
  input  logic [31:0] SD_DQ_IN
);

  localparam int unsigned CNT_MAX = (INIT_CYCLES > REFRESH_INTERVAL) ? INIT_CYCLES
                                                                     : REFRESH_INTERVAL;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  // Wait loads are "cycles until next command" minus one; the counter runs down to zero.
  localparam logic [CW-1:0] INIT_W = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] RP_W   = CW'(T_RP - 1);
  localparam logic [CW-1:0] RFC_W  = CW'(T_RFC - 1);
  localparam logic [CW-1:0] MRD_W  = CW'(T_MRD - 1);
  localparam logic [CW-1:0] RCD_W  = CW'(T_RCD - 1);
  localparam logic [CW-1:0] WR_W   = CW'(T_WR + T_RP - 1);
  localparam logic [CW-1:0] RD_W   = CW'(CAS_LAT + T_RP - 1);
  localparam logic [CW-1:0] RD_CAP = CW'(T_RP - 1);
  localparam logic [CW-1:0] REF_W  = CW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]    CAS3   = 3'(CAS_LAT);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [3:0] {
    StInitWait,
    StInitPre,
    StInitRef1,
    StInitRef2,
    StInitMrs,
    StIdle,
    StRcd,
    StWrite,
    StRead,
    StRefresh
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ref_cnt;
  logic          r_ref_pend;
  logic          r_init_done;
  logic          r_cke;
  logic [3:0]    r_cmd;
  logic [1:0]    r_ba;
  logic [11:0]   r_a;
  logic [3:0]    r_dqm;
  logic [31:0]   r_dq_out;
  logic          r_dq_oe;
  logic [31:0]   r_hrdata;
  logic [1:0]    r_req_ba;
  logic [7:0]    r_req_col;
  logic [31:0]   r_req_wdata;
  logic          r_req_write;

  logic w_busyn;
  logic w_accept;
  logic w_ref_wrap;

  assign w_busyn    = (r_state == StIdle) && !r_ref_pend;
  assign w_accept   = w_busyn && ENABLE && (W_EN || R_EN);
  assign w_ref_wrap = r_init_done && (r_ref_cnt == REF_W);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ref_cnt <= '0;
    end else if (r_init_done) begin
      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= StInitWait;
      r_cnt       <= '0;
      r_ref_pend  <= 1'b0;
      r_init_done <= 1'b0;
      r_cke       <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_ba        <= '0;
      r_a         <= '0;
      r_dqm       <= 4'hF;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_hrdata    <= '0;
      r_req_ba    <= '0;
      r_req_col   <= '0;
      r_req_wdata <= '0;
      r_req_write <= 1'b0;
    end else begin
      r_cke    <= 1'b1;
      r_cmd    <= CMD_NOP;
      r_dq_oe  <= 1'b0;
      r_dq_out <= '0;
      case (r_state)
        StInitWait: begin
          if (r_cnt == INIT_W) begin
            r_cmd   <= CMD_PRE;
            r_ba    <= '0;
            r_a     <= 12'h400;
            r_cnt   <= RP_W;
            r_state <= StInitPre;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StInitPre: begin
          if (r_cnt == '0) begin
            r_cmd   <= CMD_REF;
            r_cnt   <= RFC_W;
            r_state <= StInitRef1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StInitRef1: begin
          if (r_cnt == '0) begin
            r_cmd   <= CMD_REF;
            r_cnt   <= RFC_W;
            r_state <= StInitRef2;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StInitRef2: begin
          if (r_cnt == '0) begin
            r_cmd   <= CMD_LMR;
            r_ba    <= '0;
            r_a     <= {5'b0, CAS3, 4'b0000};
            r_cnt   <= MRD_W;
            r_state <= StInitMrs;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StInitMrs: begin
          if (r_cnt == '0) begin
            r_init_done <= 1'b1;
            r_dqm       <= 4'h0;
            r_state     <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StIdle: begin
          if (w_accept) begin
            r_req_ba    <= MEM_BA;
            r_req_col   <= MEM_ADDR[7:0];
            r_req_wdata <= MEM_WDATA;
            r_req_write <= W_EN;
            r_cmd       <= CMD_ACT;
            r_ba        <= MEM_BA;
            r_a         <= {8'h00, MEM_ADDR[11:8]};
            r_cnt       <= RCD_W;
            r_state     <= StRcd;
          end else if (r_ref_pend) begin
            r_cmd   <= CMD_REF;
            r_cnt   <= RFC_W;
            r_state <= StRefresh;
          end
        end
        StRcd: begin
          if (r_cnt == '0) begin
            r_ba <= r_req_ba;
            r_a  <= {4'b0100, r_req_col};
            if (r_req_write) begin
              r_cmd    <= CMD_WR;
              r_dq_oe  <= 1'b1;
              r_dq_out <= r_req_wdata;
              r_cnt    <= WR_W;
              r_state  <= StWrite;
            end else begin
              r_cmd   <= CMD_RD;
              r_cnt   <= RD_W;
              r_state <= StRead;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StWrite: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StRead: begin
          // Data is valid CAS_LAT cycles after READ, i.e. T_RP counts before idle.
          if (r_cnt == RD_CAP) begin
            r_hrdata <= SD_DQ_IN;
          end
          if (r_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StRefresh: begin
          if (r_cnt == '0) begin
            r_ref_pend <= 1'b0;
            r_state    <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StInitWait;
      endcase
      // A wrap landing on the same edge as a refresh completion must not be lost.
      if (w_ref_wrap) begin
        r_ref_pend <= 1'b1;
      end
    end
  end

  assign BUSYn     = w_busyn;
  assign HRDATA_R  = r_hrdata;
  assign INIT_DONE = r_init_done;
  assign SD_CKE    = r_cke;
  assign SD_CSn    = r_cmd[3];
  assign SD_RASn   = r_cmd[2];
  assign SD_CASn   = r_cmd[1];
  assign SD_WEn    = r_cmd[0];
  assign SD_BA     = r_ba;
  assign SD_A      = r_a;
  assign SD_DQM    = r_dqm;
  assign SD_DQ_OUT = r_dq_out;
  assign SD_DQ_OE  = r_dq_oe;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Self-checking bench for sdram_ctrl: a cycle-indexed schedule of expected SDRAM commands,
// busy windows and refresh wraps is derived from the timing rules and compared every cycle.
module tb_sdram_ctrl;

  localparam int INIT_CYCLES = 100;
  localparam int REF_INT     = 780;
  localparam int T_RCD       = 2;
  localparam int T_RP        = 2;
  localparam int T_RFC       = 7;
  localparam int T_MRD       = 2;
  localparam int T_WR        = 2;
  localparam int CAS_LAT     = 2;

  localparam int PRE_CYC  = INIT_CYCLES + 1;
  localparam int REF1_CYC = PRE_CYC + T_RP;
  localparam int REF2_CYC = REF1_CYC + T_RFC;
  localparam int LMR_CYC  = REF2_CYC + T_RFC;
  localparam int DONE_CYC = LMR_CYC + T_MRD;
  localparam int ACC_LEN  = 1 + T_RCD + T_WR + T_RP;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        ENABLE = 1'b0, W_EN = 1'b0, R_EN = 1'b0;
  logic [1:0]  MEM_BA = '0;
  logic [11:0] MEM_ADDR = '0;
  logic [31:0] MEM_WDATA = '0;
  logic        BUSYn, INIT_DONE, SD_CKE, SD_CSn, SD_RASn, SD_CASn, SD_WEn, SD_DQ_OE;
  logic [31:0] HRDATA_R, SD_DQ_OUT;
  logic [31:0] SD_DQ_IN = '0;
  logic [1:0]  SD_BA;
  logic [11:0] SD_A;
  logic [3:0]  SD_DQM;

  sdram_ctrl #(
    .INIT_CYCLES(INIT_CYCLES), .REFRESH_INTERVAL(REF_INT), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RFC(T_RFC), .T_MRD(T_MRD), .T_WR(T_WR), .CAS_LAT(CAS_LAT)
  ) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .ENABLE(ENABLE), .W_EN(W_EN), .R_EN(R_EN),
    .MEM_BA(MEM_BA), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .BUSYn(BUSYn),
    .HRDATA_R(HRDATA_R), .INIT_DONE(INIT_DONE), .SD_CKE(SD_CKE), .SD_CSn(SD_CSn),
    .SD_RASn(SD_RASn), .SD_CASn(SD_CASn), .SD_WEn(SD_WEn), .SD_BA(SD_BA), .SD_A(SD_A),
    .SD_DQM(SD_DQM), .SD_DQ_OUT(SD_DQ_OUT), .SD_DQ_OE(SD_DQ_OE), .SD_DQ_IN(SD_DQ_IN)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference schedule, keyed by the cycle in which an output is expected.
  logic [3:0]  e_cmd   [int];
  logic [1:0]  e_ba    [int];
  logic [11:0] e_a     [int];
  logic [31:0] e_dq    [int];
  logic [31:0] dq_drv  [int];
  logic [31:0] hr_upd  [int];
  int          m_free;
  int          m_ref_end;
  bit          m_pend;
  logic [31:0] m_rdata;

  wire [3:0] obs_cmd = {SD_CSn, SD_RASn, SD_CASn, SD_WEn};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_busyn();
    return (cyc >= DONE_CYC) && (cyc >= m_free) && !m_pend;
  endfunction

  task automatic model_reset();
    e_cmd.delete(); e_ba.delete(); e_a.delete(); e_dq.delete();
    dq_drv.delete(); hr_upd.delete();
    cyc = 0; m_free = 0; m_ref_end = -1; m_pend = 1'b0; m_rdata = '0;
    e_cmd[PRE_CYC] = PRE;
    e_cmd[REF1_CYC] = REF;
    e_cmd[REF2_CYC] = REF;
    e_cmd[LMR_CYC] = LMR; e_ba[LMR_CYC] = 2'd0; e_a[LMR_CYC] = 12'(CAS_LAT << 4);
  endtask

  task automatic check_reset();
    check("rst_cmd", obs_cmd, NOP);
    check("rst_cke", SD_CKE, 1'b0);
    check("rst_busyn", BUSYn, 1'b0);
    check("rst_init_done", INIT_DONE, 1'b0);
    check("rst_dqm", SD_DQM, 4'hF);
    check("rst_oe", SD_DQ_OE, 1'b0);
    check("rst_dqout", SD_DQ_OUT, 32'h0);
    check("rst_ba", SD_BA, 2'd0);
    check("rst_a", SD_A, 12'h0);
    check("rst_hrdata", HRDATA_R, 32'h0);
  endtask

  task automatic check_cycle();
    logic [3:0] ec;
    ec = e_cmd.exists(cyc) ? e_cmd[cyc] : NOP;
    check("cmd", obs_cmd, ec);
    if (e_cmd.exists(cyc) && ec == PRE) check("pre_a10", SD_A[10], 1'b1);
    if (e_cmd.exists(cyc) && ec != PRE && ec != REF) begin
      check("ba", SD_BA, e_ba[cyc]);
      check("a", SD_A, e_a[cyc]);
    end
    check("dq_oe", SD_DQ_OE, e_dq.exists(cyc));
    if (e_dq.exists(cyc)) check("dq_out", SD_DQ_OUT, e_dq[cyc]);
    check("busyn", BUSYn, m_busyn());
    check("init_done", INIT_DONE, cyc >= DONE_CYC);
    check("cke", SD_CKE, 1'b1);
    check("dqm", SD_DQM, (cyc >= DONE_CYC) ? 4'h0 : 4'hF);
    if (hr_upd.exists(cyc)) m_rdata = hr_upd[cyc];
    check("hrdata", HRDATA_R, m_rdata);
  endtask

  // Present inputs for the current cycle, advance the model across the closing edge,
  // then check the outputs of the new cycle. dat is write data or the DQ read return.
  task automatic step(input bit en, input bit w, input bit r, input logic [1:0] ba,
                      input logic [11:0] addr, input logic [31:0] dat);
    int  c;
    bit  wrap;
    c = cyc;
    ENABLE = en; W_EN = w; R_EN = r; MEM_BA = ba; MEM_ADDR = addr; MEM_WDATA = dat;
    if (m_busyn() && en && (w || r)) begin
      e_cmd[c+1] = ACT; e_ba[c+1] = ba; e_a[c+1] = {8'h00, addr[11:8]};
      e_cmd[c+1+T_RCD] = w ? WR : RD;
      e_ba[c+1+T_RCD] = ba;
      e_a[c+1+T_RCD] = {4'b0100, addr[7:0]};
      if (w) begin
        e_dq[c+1+T_RCD] = dat;
      end else begin
        dq_drv[c+1+T_RCD+CAS_LAT] = dat;
        hr_upd[c+2+T_RCD+CAS_LAT] = dat;
      end
      m_free = c + ACC_LEN;
    end else if (c >= DONE_CYC && c >= m_free && m_pend) begin
      e_cmd[c+1] = REF;
      m_free = c + 1 + T_RFC;
      m_ref_end = m_free;
    end
    wrap = (c >= DONE_CYC) && ((c - DONE_CYC) % REF_INT == REF_INT - 1);
    if (wrap) m_pend = 1'b1;
    else if (c + 1 == m_ref_end) m_pend = 1'b0;
    @(posedge HCLK);
    #1;
    cyc++;
    SD_DQ_IN = dq_drv.exists(cyc) ? dq_drv[cyc] : $urandom;
    check_cycle();
  endtask

  task automatic idle_to(input int target);
    while (cyc < target) step(1'b0, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
  endtask

  task automatic wait_free();
    for (int i = 0; i < 40 && !m_busyn(); i++) step(1'b0, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    check_reset();
    HRESET = 1'b0;
    idle_to(DONE_CYC + 3);

    // Directed write, read-back and hold of read data through a later write.
    step(1'b1, 1'b1, 1'b0, 2'b01, 12'h3A5, 32'hDEADBEEF);
    wait_free();
    step(1'b1, 1'b0, 1'b1, 2'b01, 12'h3A5, 32'hCAFEF00D);
    wait_free();
    step(1'b1, 1'b1, 1'b0, 2'b10, 12'hF00, 32'h12345678);
    wait_free();

    // Enable without direction is ignored; both directions resolve to a write.
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b11, 12'h123, 32'hAAAA5555);
    step(1'b1, 1'b1, 1'b1, 2'b11, 12'h0FF, 32'h5555AAAA);
    wait_free();

    // Read accepted on the refresh-wrap edge: read first, refresh right after.
    idle_to(DONE_CYC + REF_INT - 1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 12'h7C3, 32'h0BADF00D);
    idle_to(cyc + 20);

    for (int i = 0; i < 1100; i++) begin
      step(($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           2'($urandom), 12'($urandom), $urandom);
    end
    wait_free();

    // Reset between ACTIVE and READ, then a complete re-initialisation.
    step(1'b1, 1'b0, 1'b1, 2'b10, 12'h456, 32'h11223344);
    step(1'b0, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
    HRESET = 1'b1;
    #2;
    check_reset();
    @(posedge HCLK);
    #1;
    check_reset();
    HRESET = 1'b0;
    model_reset();
    idle_to(DONE_CYC + 2);
    step(1'b1, 1'b0, 1'b1, 2'b01, 12'h3A5, 32'h600DCAFE);
    wait_free();
    idle_to(cyc + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
